// File: rtl/mips_program_loader.sv
// -----------------------------------------------------------------------------
// mips_program_loader
//
// Writer side of the instruction-memory interface. A byte stream of the form
//   SYNC_BYTE, LEN_HI, LEN_LO, N x (4 bytes, big-endian word)
// is packed into 32-bit words and written to program memory. The MIPS core is
// held in reset until a complete image has been written; a frame that claims
// more words than the memory can hold sends the loader to a sticky error state
// that only reset clears.
//
// Optional feature (compile-time macro LOADER_CHECKSUM_EN):
//   An 8-bit XOR of all payload bytes is kept, and one trailing checksum byte
//   is compared against it before the core is released. For N==0 the expected
//   checksum is 8'h00. With the macro undefined there is no CHECK state and no
//   checksum register.
//
// Ports
//   clk_i         clock, rising edge
//   reset_i       synchronous active-high reset
//   rx_data_i     incoming byte
//   rx_valid_i    rx_data_i is valid
//   rx_ready_o    loader accepts a byte (transfer on rx_valid_i && rx_ready_o)
//   imem_we_o     one-cycle program-memory write strobe
//   imem_addr_o   word address of the write
//   imem_wdata_o  instruction word being written
//   cpu_reset_o   reset to the MIPS core, high until the image is loaded
//   done_o        image loaded, core running
//   error_o       load failed (sticky until reset)
// -----------------------------------------------------------------------------
module mips_program_loader #(
  parameter int unsigned MEMORY_DEPTH = 256,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o,
  output logic                  imem_we_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  output logic [31:0]           imem_wdata_o,
  output logic                  cpu_reset_o,
  output logic                  done_o,
  output logic                  error_o
);

  localparam logic [15:0] DEPTH_W = 16'(MEMORY_DEPTH);

  typedef enum logic [2:0] {
    ST_SYNC   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
`ifdef LOADER_CHECKSUM_EN
    ST_CHECK  = 3'd4,
`endif
    ST_RUN    = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  state_t                  state_q;
  logic [15:0]             count_q;
  logic [23:0]             word_q;      // first three bytes of the word in flight
  logic [1:0]              byte_cnt_q;
  logic [15:0]             word_idx_q;
  logic                    imem_we_q;
  logic [ADDR_WIDTH-1:0]   imem_addr_q;
  logic [31:0]             imem_wdata_q;
  logic                    cpu_reset_q;
  logic                    done_q;
  logic                    error_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]              chk_q;
  logic [7:0]              chk_d;
`endif

  logic                    accept_s;
  logic [15:0]             count_d;
  logic [31:0]             word_d;
  logic                    last_word_s;

  assign accept_s    = rx_valid_i & rx_ready_o;
  assign count_d     = {count_q[15:8], rx_data_i};
  assign word_d      = {word_q, rx_data_i};
  assign last_word_s = (word_idx_q == (count_q - 16'd1));
`ifdef LOADER_CHECKSUM_EN
  assign chk_d       = chk_q ^ rx_data_i;
`endif

  // The only state that refuses bytes is ERROR, which is exactly when error_q is set.
  assign rx_ready_o   = ~reset_i & ~error_q;
  assign imem_we_o    = imem_we_q;
  assign imem_addr_o  = imem_addr_q;
  assign imem_wdata_o = imem_wdata_q;
  assign cpu_reset_o  = cpu_reset_q;
  assign done_o       = done_q;
  assign error_o      = error_q;

  // Loader state machine with registered memory-port and core-control outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_SYNC;
      count_q      <= 16'd0;
      word_q       <= 24'd0;
      byte_cnt_q   <= 2'd0;
      word_idx_q   <= 16'd0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'd0;
      cpu_reset_q  <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      chk_q        <= 8'd0;
`endif
    end else begin
      // Write strobe lasts exactly one cycle; address/data hold their values.
      imem_we_q <= 1'b0;
      case (state_q)
        ST_SYNC: begin
          if (accept_s && (rx_data_i == SYNC_BYTE)) begin
            state_q <= ST_LEN_HI;
`ifdef LOADER_CHECKSUM_EN
            chk_q   <= 8'd0;
`endif
          end
        end
        ST_LEN_HI: begin
          if (accept_s) begin
            count_q[15:8] <= rx_data_i;
            state_q       <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (accept_s) begin
            count_q <= count_d;
            if (count_d == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
              state_q <= ST_CHECK;
`else
              // Empty image: release the core right away.
              state_q     <= ST_RUN;
              cpu_reset_q <= 1'b0;
              done_q      <= 1'b1;
`endif
            end else if (count_d > DEPTH_W) begin
              state_q <= ST_ERROR;
              error_q <= 1'b1;
            end else begin
              state_q    <= ST_DATA;
              byte_cnt_q <= 2'd0;
              word_idx_q <= 16'd0;
            end
          end
        end
        ST_DATA: begin
          if (accept_s) begin
            word_q     <= word_d[23:0];
            byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            chk_q      <= chk_d;
`endif
            if (byte_cnt_q == 2'd3) begin
              imem_we_q    <= 1'b1;
              imem_wdata_q <= word_d;
              imem_addr_q  <= word_idx_q[ADDR_WIDTH-1:0];
              word_idx_q   <= word_idx_q + 16'd1;
              // RUN outputs follow one cycle later, i.e. after the last write strobe.
              if (last_word_s) begin
`ifdef LOADER_CHECKSUM_EN
                state_q <= ST_CHECK;
`else
                state_q <= ST_RUN;
`endif
              end
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (accept_s) begin
            if (rx_data_i == chk_q) begin
              state_q     <= ST_RUN;
              cpu_reset_q <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              state_q <= ST_ERROR;
              error_q <= 1'b1;
            end
          end
        end
`endif
        ST_RUN: begin
          // Bytes are still accepted here and simply dropped.
          cpu_reset_q <= 1'b0;
          done_q      <= 1'b1;
        end
        ST_ERROR: begin
          cpu_reset_q <= 1'b1;
          done_q      <= 1'b0;
          error_q     <= 1'b1;
        end
        default: begin
          state_q     <= ST_ERROR;
          cpu_reset_q <= 1'b1;
          done_q      <= 1'b0;
          error_q     <= 1'b1;
        end
      endcase
    end
  end

endmodule
